// File: rtl/spi_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter_if
// Command/response channel between one requester and spi_ram_arbiter.
//   cmd      [9:0]  {op[1:0], payload[7:0]} from requester
//   valid           command valid, held until ready
//   ready           command accepted this cycle
//   rd_data  [7:0]  last read data returned to this requester
//   rd_valid        one-cycle pulse, rd_data updated
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface spi_ram_arbiter_if;
    logic [9:0] cmd;
    logic       valid;
    logic       ready;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output cmd,
        output valid,
        input  ready,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  cmd,
        input  valid,
        output ready,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter
// Shares one single-port synchronous 8-bit RAM between two command
// requesters (r0 = SPI slave, r1 = local host). Each requester owns its own
// write/read address registers. Accesses are granted round-robin and read
// data is returned on the channel of the requester that issued the read.
//
// Ports
//   clk        clock, posedge
//   rst_n      synchronous active-low reset
//   r0, r1     requester channels (spi_ram_arbiter_if.slave)
//   mem_en     RAM access enable (registered)
//   mem_we     RAM write enable (registered)
//   mem_addr   RAM address (registered)
//   mem_wdata  RAM write data (registered)
//   mem_rdata  RAM read data, valid one cycle after a read strobe
//   busy       FSM is not in IDLE
// ---------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_ram_arbiter_if.slave     r0,
    spi_ram_arbiter_if.slave     r1,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] RD_WAIT = 2'd3;

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

    logic [1:0]           state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic [ADDR_SIZE-1:0] wr_addr_q [2];
    logic [ADDR_SIZE-1:0] wr_addr_d [2];
    logic [ADDR_SIZE-1:0] rd_addr_q [2];
    logic [ADDR_SIZE-1:0] rd_addr_d [2];
    logic [7:0]           rd_data_q [2];
    logic [7:0]           rd_data_d [2];
    logic [1:0]           rd_valid_q, rd_valid_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;

    logic       idle;
    logic       gnt1;
    logic       acc0;
    logic       acc1;
    logic       sel;
    logic [9:0] cmd_sel;

    assign idle = (state_q == IDLE);

    // On a tie the requester that was not served last wins.
    assign gnt1 = r1.valid & (~r0.valid | ~last_grant_q);

    // Nothing is accepted while reset is asserted, so no command is lost.
    assign acc1 = rst_n & idle & gnt1;
    assign acc0 = rst_n & idle & r0.valid & ~gnt1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = '0;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        sel          = acc1;
        cmd_sel      = acc1 ? r1.cmd : r0.cmd;

        case (state_q)
            IDLE: begin
                if (acc0 | acc1) begin
                    last_grant_d = sel;
                    owner_d      = sel;
                    case (cmd_sel[9:8])
                        OP_SET_WR: wr_addr_d[sel] = cmd_sel[ADDR_SIZE-1:0];
                        OP_SET_RD: rd_addr_d[sel] = cmd_sel[ADDR_SIZE-1:0];
                        OP_WRITE: begin
                            mem_en_d    = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_addr_q[sel];
                            mem_wdata_d = cmd_sel[7:0];
                            state_d     = WRITE;
                        end
                        OP_READ: begin
                            mem_en_d   = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = rd_addr_q[sel];
                            state_d    = READ;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WRITE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
                if (AUTO_INC) begin
                    wr_addr_d[owner_q] = wr_addr_q[owner_q] + ADDR_ONE;
                end
            end
            READ: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                rd_data_d[owner_q]  = mem_rdata;
                rd_valid_d[owner_q] = 1'b1;
                state_d             = IDLE;
                if (AUTO_INC) begin
                    rd_addr_d[owner_q] = rd_addr_q[owner_q] + ADDR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_addr_q    <= '{default: '0};
            rd_addr_q    <= '{default: '0};
            rd_data_q    <= '{default: '0};
            rd_valid_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign r0.ready    = acc0;
    assign r1.ready    = acc1;
    assign r0.rd_data  = rd_data_q[0];
    assign r1.rd_data  = rd_data_q[1];
    assign r0.rd_valid = rd_valid_q[0];
    assign r1.rd_valid = rd_valid_q[1];

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = ~idle;

endmodule
